rm_ihpsg13_bist_march_ctrl: RTL and testbench
=============================================

// Module: rm_ihpsg13_bist_march_ctrl
// PURPOSE
// - March C- BIST engine. Drives the A_BIST_* port group of a 1P SRAM macro with byte/bit mask and BIST mux.
// - Checks the macro's A_DOUT and reports pass/fail, first failing address and error count.
// - Sits directly upstream of the macro; one instance per macro; shares the macro's BIST clock.
// PARAMETERS
// - P_DATA_WIDTH  64  SRAM word width; DIN, BM and DOUT are all this width.
// - P_ADDR_WIDTH  9   SRAM address width; N = 2**P_ADDR_WIDTH words.
// - P_ERRCNT_W    16  Width of the saturating mismatch counter.
// PORTS
// - A_BIST_CLK    in   1   BIST clock, also drives the macro's A_BIST_CLK.
// - A_BIST_RST_N  in   1   Asynchronous, active-low reset.
// - A_START       in   1   Start pulse; sampled on posedge in IDLE or DONE only.
// - A_BIST_EN     out  1   Macro BIST mux select; high in RUN and DRAIN.
// - A_BIST_MEN    out  1   Macro enable; high on every op cycle.
// - A_BIST_WEN    out  1   Write op.
// - A_BIST_REN    out  1   Read op. Never high in the same cycle as WEN.
// - A_BIST_ADDR   out  P_ADDR_WIDTH   Op address.
// - A_BIST_DIN    out  P_DATA_WIDTH   Write data: all-0 or all-1 background.
// - A_BIST_BM     out  P_DATA_WIDTH   Bit mask; constant all-1.
// - A_DOUT        in   P_DATA_WIDTH   Macro read data; valid one cycle after a read op.
// - A_BUSY        out  1   High in RUN and DRAIN.
// - A_DONE        out  1   Sticky completion flag; cleared by a new accepted start or by reset.
// - A_FAIL        out  1   Sticky: at least one mismatch in the current or last run.
// - A_FAIL_ADDR   out  P_ADDR_WIDTH   Address of the first mismatch.
// - A_FAIL_CNT    out  P_ERRCNT_W     Mismatching read count; saturates at all-1.
// BEHAVIOUR
// Reset values
// - While reset is asserted, all outputs are 0 (DIN 0, BM 0) and the FSM is in IDLE.
// - Reset asserted mid-run aborts the run immediately.
// FSM states: IDLE -> RUN -> DRAIN -> DONE -> (start) RUN
// - START accepted in IDLE/DONE: clears DONE, FAIL, FAIL_ADDR, FAIL_CNT.
// - START in RUN or DRAIN is ignored.
// RUN: one op per cycle, no bubbles. Elements E0..E5, executed in order:
// - E0 up(w0)
// - E1 up(r0,w1)
// - E2 up(r1,w0)
// - E3 down(r0,w1)
// - E4 down(r1,w0)
// - E5 up(r0)
// - "up" runs addr 0..N-1; "down" runs addr N-1..0.
// - Within an element, all ops complete on one address before the address steps.
// - Total ops = 10N. Element change on address wrap: no idle cycle between elements.
// Op issue timing
// - Ops are registered outputs: START sampled at edge 0 -> op 1 visible after edge 0, taken by the macro at edge 1.
// - The last op is taken at edge 10N. The FSM then enters DRAIN for 1 cycle.
// - A_DONE rises after edge 10N+1; A_BUSY falls on the same edge.
// - In DRAIN/DONE/IDLE: MEN=WEN=REN=0. ADDR/DIN hold their last value. BM=all-1 from the first accepted start.
// Checking
// - Each read op registers {expected background, address, check_valid}.
// - At the next edge, A_DOUT is compared against the expected value (all-0 or all-1, full width).
// - A mismatch increments FAIL_CNT (saturating) and sets FAIL.
// - A mismatch latches FAIL_ADDR only if FAIL was previously 0.
// - The final E5 read at N-1 is checked at the DRAIN edge; it is counted before DONE rises.
// Width rules
// - Address counter is P_ADDR_WIDTH bits; wrap detection uses the terminal value (N-1 going up, 0 going down), not overflow.
// - P_ADDR_WIDTH >= 1.
// TESTING
// - T1 fault-free run (P_ADDR_WIDTH=9, behavioural macro): START pulse
//   -> DONE after exactly 5121 cycles, FAIL=0, FAIL_CNT=0, 2560 writes and 2560 reads issued.
// - T2 sequence check (P_ADDR_WIDTH=2): log ops
//   -> w0@0..3; r0w1@0,1,2,3; r1w0@0..3; r0w1@3,2,1,0; r1w0@3..0; r0@0..3. 40 op cycles, no gaps.
// - T3 stuck-at-1 injected on bit 17 of addr 0x05
//   -> FAIL=1, FAIL_ADDR=0x05, FAIL_CNT=3 (the r0 reads in E1, E3, E5).
// - T4 saturation (P_ERRCNT_W=2): DOUT forced to 0x5555..5555
//   -> FAIL_CNT=3 at DONE, FAIL_ADDR=0.
// - T5 control robustness
//   -> START while BUSY is ignored: DONE timing unchanged.
//   -> A_BIST_RST_N low at op 3000: all outputs 0 asynchronously.
//   -> A later START runs a full clean pass.
// - T6 back-to-back runs: START while DONE=1 after a failing run
//   -> FAIL, FAIL_ADDR and FAIL_CNT clear at the start edge; the second run on fault-free memory ends with FAIL=0.

Source files
------------

// File: rtl/rm_ihpsg13_bist_march_ctrl.sv
// March C- BIST controller for a single-port SRAM macro: sequences the A_BIST_* port group
// and checks A_DOUT, reporting pass/fail, first failing address and a saturating error count.
module rm_ihpsg13_bist_march_ctrl #(
    parameter int unsigned P_DATA_WIDTH = 64,
    parameter int unsigned P_ADDR_WIDTH = 9,
    parameter int unsigned P_ERRCNT_W   = 16
) (
    input  logic                    A_BIST_CLK,
    input  logic                    A_BIST_RST_N,
    input  logic                    A_START,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [P_ERRCNT_W-1:0]   A_FAIL_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [2:0]              ELEM_LAST = 3'd5;

    logic [1:0]              state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic                    opidx_q, opidx_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    men_q, men_d;
    logic                    wen_q, wen_d;
    logic                    ren_q, ren_d;
    logic                    bg_q, bg_d;
    logic                    bm_q, bm_d;
    logic                    chk_valid_q, chk_valid_d;
    logic                    chk_exp_q, chk_exp_d;
    logic [P_ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [P_ERRCNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic start_ok;
    logic last_op;
    logic at_term;
    logic issue;

    // Element table: E3/E4 walk downwards, E0/E5 have a single op, the rest two.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_last_idx(input logic [2:0] e);
        return !((e == 3'd0) || (e == ELEM_LAST));
    endfunction

    function automatic logic op_write(input logic [2:0] e, input logic i);
        return (e == 3'd0) || ((e != ELEM_LAST) && i);
    endfunction

    function automatic logic op_bg(input logic [2:0] e, input logic i);
        logic b;
        b = 1'b0;
        if ((e == 3'd1) || (e == 3'd3)) b = i;
        if ((e == 3'd2) || (e == 3'd4)) b = ~i;
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        opidx_d     = opidx_q;
        addr_d      = addr_q;
        men_d       = men_q;
        wen_d       = wen_q;
        ren_d       = ren_q;
        bg_d        = bg_q;
        bm_d        = bm_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;
        issue       = 1'b0;

        // The op presented this cycle is taken at the coming edge; its read is checked one edge later.
        chk_valid_d = ren_q;
        chk_exp_d   = bg_q;
        chk_addr_d  = addr_q;

        start_ok = A_START && ((state_q == S_IDLE) || (state_q == S_DONE));
        last_op  = (opidx_q == elem_last_idx(elem_q));
        at_term  = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d     = S_RUN;
                    elem_d      = '0;
                    opidx_d     = 1'b0;
                    addr_d      = '0;
                    bm_d        = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_cnt_d  = '0;
                    issue       = 1'b1;
                end
            end
            S_RUN: begin
                if (!last_op) begin
                    opidx_d = 1'b1;
                    issue   = 1'b1;
                end else if (!at_term) begin
                    opidx_d = 1'b0;
                    addr_d  = elem_down(elem_q) ? (addr_q - P_ADDR_WIDTH'(1))
                                                : (addr_q + P_ADDR_WIDTH'(1));
                    issue   = 1'b1;
                end else if (elem_q == ELEM_LAST) begin
                    state_d = S_DRAIN;
                    men_d   = 1'b0;
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                end else begin
                    elem_d  = elem_q + 3'd1;
                    opidx_d = 1'b0;
                    addr_d  = elem_down(elem_q + 3'd1) ? ADDR_LAST : '0;
                    issue   = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            men_d = 1'b1;
            wen_d = op_write(elem_d, opidx_d);
            ren_d = ~op_write(elem_d, opidx_d);
            bg_d  = op_bg(elem_d, opidx_d);
        end

        if (chk_valid_q && (A_DOUT != {P_DATA_WIDTH{chk_exp_q}})) begin
            fail_d = 1'b1;
            if (!fail_q) fail_addr_d = chk_addr_q;
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + P_ERRCNT_W'(1);
        end
    end

    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
        if (!A_BIST_RST_N) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            opidx_q     <= 1'b0;
            addr_q      <= '0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            bg_q        <= 1'b0;
            bm_q        <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_exp_q   <= 1'b0;
            chk_addr_q  <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            opidx_q     <= opidx_d;
            addr_q      <= addr_d;
            men_q       <= men_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            bg_q        <= bg_d;
            bm_q        <= bm_d;
            chk_valid_q <= chk_valid_d;
            chk_exp_q   <= chk_exp_d;
            chk_addr_q  <= chk_addr_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign A_BUSY      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign A_BIST_EN   = A_BUSY;
    assign A_BIST_MEN  = men_q;
    assign A_BIST_WEN  = wen_q;
    assign A_BIST_REN  = ren_q;
    assign A_BIST_ADDR = addr_q;
    assign A_BIST_DIN  = {P_DATA_WIDTH{bg_q}};
    assign A_BIST_BM   = {P_DATA_WIDTH{bm_q}};
    assign A_DONE      = done_q;
    assign A_FAIL      = fail_q;
    assign A_FAIL_ADDR = fail_addr_q;
    assign A_FAIL_CNT  = fail_cnt_q;

endmodule

// File: tb/tb_rm_ihpsg13_bist_march_ctrl.sv
// Directed bench for rm_ihpsg13_bist_march_ctrl: a 512-word instance with a behavioural macro
// and fault injection, plus a 4-word instance for op-sequence and counter saturation checks.
module tb_rm_ihpsg13_bist_march_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // 512 x 64 instance
    logic        m_rst_n, m_start;
    logic        m_en, m_men, m_wen, m_ren, m_busy, m_done, m_fail;
    logic [8:0]  m_addr, m_fail_addr;
    logic [63:0] m_din, m_bm, m_dout;
    logic [15:0] m_fail_cnt;
    logic        fault_en;
    logic [63:0] mem [512];

    // 4 x 8 instance, read data pinned to an alternating pattern
    logic        s_rst_n, s_start;
    logic        s_en, s_men, s_wen, s_ren, s_busy, s_done, s_fail;
    logic [1:0]  s_addr, s_fail_addr;
    logic [7:0]  s_din, s_bm;
    logic [7:0]  s_dout;
    logic [1:0]  s_fail_cnt;
    assign s_dout = 8'h55;

    rm_ihpsg13_bist_march_ctrl #(.P_DATA_WIDTH(64), .P_ADDR_WIDTH(9), .P_ERRCNT_W(16)) u_main (
        .A_BIST_CLK(clk), .A_BIST_RST_N(m_rst_n), .A_START(m_start),
        .A_BIST_EN(m_en), .A_BIST_MEN(m_men), .A_BIST_WEN(m_wen), .A_BIST_REN(m_ren),
        .A_BIST_ADDR(m_addr), .A_BIST_DIN(m_din), .A_BIST_BM(m_bm), .A_DOUT(m_dout),
        .A_BUSY(m_busy), .A_DONE(m_done), .A_FAIL(m_fail),
        .A_FAIL_ADDR(m_fail_addr), .A_FAIL_CNT(m_fail_cnt)
    );

    rm_ihpsg13_bist_march_ctrl #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(2), .P_ERRCNT_W(2)) u_small (
        .A_BIST_CLK(clk), .A_BIST_RST_N(s_rst_n), .A_START(s_start),
        .A_BIST_EN(s_en), .A_BIST_MEN(s_men), .A_BIST_WEN(s_wen), .A_BIST_REN(s_ren),
        .A_BIST_ADDR(s_addr), .A_BIST_DIN(s_din), .A_BIST_BM(s_bm), .A_DOUT(s_dout),
        .A_BUSY(s_busy), .A_DONE(s_done), .A_FAIL(s_fail),
        .A_FAIL_ADDR(s_fail_addr), .A_FAIL_CNT(s_fail_cnt)
    );

    // Behavioural macro: registered read, optional stuck-at-1 on bit 17 of word 0x05
    always @(posedge clk) begin
        if (m_men) begin
            if (m_wen) mem[m_addr] <= m_din;
            if (m_ren) m_dout <= mem[m_addr] | ((fault_en && m_addr == 9'h005) ? (64'd1 << 17) : 64'd0);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a run on the main instance; returns at DONE, at stop_at, or after the cycle budget.
    task automatic run_main(input int extra_at, input int stop_at,
                            output int cycles, output int nw, output int nr);
        @(negedge clk) m_start = 1'b1;
        @(posedge clk);
        @(negedge clk) m_start = 1'b0;
        cycles = 0; nw = 0; nr = 0;
        check("start_clear", {m_done, m_fail, m_fail_addr, m_fail_cnt}, '0);
        check("start_op1", {m_busy, m_en, m_men, m_wen, m_ren, m_addr, m_din}, {5'b11110, 9'd0, 64'd0});
        check("start_bm", m_bm, {64{1'b1}});
        while (cycles < 6000 && !m_done && cycles != stop_at) begin
            nw += int'(m_wen);
            nr += int'(m_ren);
            m_start = (cycles == extra_at);
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        m_start = 1'b0;
    endtask

    logic [159:0] seq;
    logic [3:0]   nib;
    int cyc, nw, nr;

    initial begin
        m_rst_n = 1'b0; s_rst_n = 1'b0;
        m_start = 1'b0; s_start = 1'b0;
        fault_en = 1'b0;
        // Op nibble = {write, data, addr[1:0]} for the 4-word March C- sequence
        seq = 160'h89AB_0C1D2E3F_48596A7B_3F2E1D0C_7B6A5948_0123;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {m_en, m_men, m_wen, m_ren, m_busy, m_done, m_fail}, '0);
        check("rst_addr", {m_addr, m_fail_addr, m_fail_cnt}, '0);
        check("rst_din_bm", {m_din, m_bm}, '0);
        check("rst_small", {s_en, s_men, s_busy, s_done, s_fail, s_addr, s_din, s_bm, s_fail_cnt}, '0);
        m_rst_n = 1'b1; s_rst_n = 1'b1;

        // Op sequence and saturating counter on the 4-word instance
        @(negedge clk) s_start = 1'b1;
        @(posedge clk);
        @(negedge clk) s_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            nib = seq[159 - 4*k -: 4];
            check($sformatf("seq_op%0d", k),
                  {s_busy, s_men, s_wen, s_ren, s_addr, (s_wen ? s_din : 8'h00)},
                  {1'b1, 1'b1, nib[3], ~nib[3], nib[1:0], (nib[3] ? {8{nib[2]}} : 8'h00)});
            @(posedge clk);
            @(negedge clk);
        end
        check("seq_drain", {s_busy, s_men, s_wen, s_ren, s_done}, 5'b10000);
        @(posedge clk);
        @(negedge clk);
        check("sat_done", {s_busy, s_en, s_done, s_fail, s_fail_addr, s_fail_cnt}, {4'b0011, 2'd0, 2'd3});
        check("sat_hold", {s_men, s_addr, s_din, s_bm}, {1'b0, 2'd3, 8'h00, 8'hFF});

        // Fault-free full run
        run_main(-1, -1, cyc, nw, nr);
        check("t1_cycles", cyc, 5121);
        check("t1_writes", nw, 2560);
        check("t1_reads", nr, 2560);
        check("t1_result", {m_busy, m_done, m_fail, m_fail_cnt}, {3'b010, 16'd0});

        // Stuck-at-1 at word 0x05 bit 17
        fault_en = 1'b1;
        run_main(-1, -1, cyc, nw, nr);
        check("t3_cycles", cyc, 5121);
        check("t3_result", {m_done, m_fail, m_fail_addr, m_fail_cnt}, {2'b11, 9'h005, 16'd3});

        // Restart from DONE after a failing run, with a START pulse mid-run that must be ignored
        fault_en = 1'b0;
        run_main(100, -1, cyc, nw, nr);
        check("t6_cycles", cyc, 5121);
        check("t6_result", {m_done, m_fail, m_fail_addr, m_fail_cnt}, {2'b10, 9'h000, 16'd0});

        // Asynchronous reset with op 3000 on the port
        run_main(-1, 2999, cyc, nw, nr);
        check("t5_inflight", {m_busy, m_men}, 2'b11);
        m_rst_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {m_en, m_men, m_wen, m_ren, m_busy, m_done, m_fail}, '0);
        check("t5_rst_data", {m_addr, m_fail_addr, m_fail_cnt, m_din, m_bm}, '0);
        @(negedge clk) m_rst_n = 1'b1;
        run_main(-1, -1, cyc, nw, nr);
        check("t5_cycles", cyc, 5121);
        check("t5_counts", {nw[15:0], nr[15:0]}, {16'd2560, 16'd2560});
        check("t5_result", {m_done, m_fail, m_fail_cnt}, {2'b10, 16'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
